// File: rtl/misr_sig_analyzer.sv
// misr_sig_analyzer: folds a window of accepted chip output words into a
// Galois MISR signature, then compares the result with a golden value.
// Latency: a sample updates sig on its accepting edge. done and pass rise on
// the edge that accepts the last sample of the window.
// Backpressure: none. data_valid is a strobe and never stalls. Gaps between
// samples hold the state.
//
// Ports:
//   clk, rst_n    rising-edge clock and asynchronous active-low reset
//   start         begin a run (honoured in IDLE and DONE only)
//   abort         cancel the run and return to IDLE (beats start/data_valid)
//   data_valid    data_in is accepted this cycle (RUN only)
//   data_in       word to compact into the signature
//   expected_sig  golden signature, held stable for the whole run
//   sig           current signature register
//   count         samples accepted in the current run (saturates at WINDOW)
//   busy / done   RUN / DONE state decodes
//   pass          final signature matched expected_sig (meaningful with done)
module misr_sig_analyzer #(
  parameter int unsigned          WIDTH  = 4,
  parameter logic [WIDTH-1:0]     POLY   = 4'b0011,
  parameter logic [WIDTH-1:0]     SEED   = 4'b0000,
  parameter int unsigned          WINDOW = 16,
  parameter int unsigned          CW     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] expected_sig,
  output logic [WIDTH-1:0] sig,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WINDOW);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pass_q, pass_d;

  // Galois step: shift left, fold the escaping MSB back through POLY, then
  // mix in the new word.
  logic [WIDTH-1:0] sig_next;
  assign sig_next = {sig_q[WIDTH-2:0], 1'b0}
                  ^ (sig_q[WIDTH-1] ? POLY : '0)
                  ^ data_in;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    count_d = count_q;
    pass_d  = pass_q;

    if (abort) begin
      // sig is kept on purpose so the partial signature can be inspected.
      state_d = S_IDLE;
      count_d = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            sig_d   = SEED;
            count_d = '0;
            pass_d  = 1'b0;
          end
        end

        S_RUN: begin
          if (data_valid) begin
            sig_d   = sig_next;
            count_d = count_q + CW'(1);
            // The last sample closes the window. The verdict is taken on
            // sig_next because sig_q does not hold the final value yet.
            if (count_q == LAST_IDX) begin
              state_d = S_DONE;
              count_d = FULL_CNT;
              pass_d  = (sig_next == expected_sig);
            end
          end
        end

        S_DONE: begin
          // A restart goes straight back to RUN. There is no IDLE bubble.
          if (start) begin
            state_d = S_RUN;
            sig_d   = SEED;
            count_d = '0;
            pass_d  = 1'b0;
          end
        end

        default: begin
          state_d = S_IDLE;
          count_d = '0;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sig_q   <= '0;
      count_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      count_q <= count_d;
      pass_q  <= pass_d;
    end
  end

  assign sig   = sig_q;
  assign count = count_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign pass  = pass_q;

endmodule

// File: tb/tb_misr_sig_analyzer.sv
// tb_misr_sig_analyzer: three analyzers (WINDOW = 2, 16 and 1) share one
// stimulus stream. Each one is tracked by a sample-list reference model.
// Directed table rows and sequences cover the corner cases. A random phase
// follows.
module tb_misr_sig_analyzer;

  localparam int NI = 3;
  localparam int WIN [NI] = '{2, 16, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, dv;
  logic [3:0]  din, exp_sig;

  logic [3:0]  d_sig  [NI];
  logic [15:0] d_cnt  [NI];
  logic        d_busy [NI];
  logic        d_done [NI];
  logic        d_pass [NI];

  always #5 clk = ~clk;

  misr_sig_analyzer #(.WINDOW(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .data_valid(dv), .data_in(din), .expected_sig(exp_sig),
    .sig(d_sig[0]), .count(d_cnt[0]), .busy(d_busy[0]),
    .done(d_done[0]), .pass(d_pass[0]));

  misr_sig_analyzer #(.WINDOW(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .data_valid(dv), .data_in(din), .expected_sig(exp_sig),
    .sig(d_sig[1]), .count(d_cnt[1]), .busy(d_busy[1]),
    .done(d_done[1]), .pass(d_pass[1]));

  misr_sig_analyzer #(.WINDOW(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .data_valid(dv), .data_in(din), .expected_sig(exp_sig),
    .sig(d_sig[2]), .count(d_cnt[2]), .busy(d_busy[2]),
    .done(d_done[2]), .pass(d_pass[2]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: a run is the list of samples accepted so far. The
  // signature is that list folded from the seed.
  bit         m_run  [NI];
  bit         m_done [NI];
  bit         m_pass [NI];
  int         m_n    [NI];
  logic [3:0] m_sig  [NI];
  logic [3:0] m_smp  [NI][16];

  // One MISR step as polynomial arithmetic: multiply by x mod x^4+x+1, add d.
  function automatic int mulx_add(input int s, input int d);
    int t;
    t = (s * 2) % 16;
    if (s >= 8) t = t ^ 3;
    return t ^ d;
  endfunction

  function automatic logic [3:0] fold(input int i);
    int s;
    s = 0;
    for (int k = 0; k < m_n[i]; k++) s = mulx_add(s, int'(m_smp[i][k]));
    return 4'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_n[i] = 0; m_sig[i] = 4'h0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (abort) begin
        m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_n[i] = 0;
      end else if (!m_run[i]) begin
        if (start) begin
          m_run[i] = 1; m_done[i] = 0; m_pass[i] = 0; m_n[i] = 0;
          m_sig[i] = 4'h0;
        end
      end else if (dv) begin
        m_smp[i][m_n[i]] = din;
        m_n[i]++;
        m_sig[i] = fold(i);
        if (m_n[i] == WIN[i]) begin
          m_run[i]  = 0;
          m_done[i] = 1;
          m_pass[i] = (m_sig[i] == exp_sig);
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("w%0d.sig", WIN[i]),   int'(d_sig[i]),  int'(m_sig[i]));
      chk($sformatf("w%0d.count", WIN[i]), int'(d_cnt[i]),  m_n[i]);
      chk($sformatf("w%0d.busy", WIN[i]),  int'(d_busy[i]), int'(m_run[i]));
      chk($sformatf("w%0d.done", WIN[i]),  int'(d_done[i]), int'(m_done[i]));
      chk($sformatf("w%0d.pass", WIN[i]),  int'(d_pass[i]), int'(m_pass[i]));
    end
  endtask

  // Inputs are set between edges. The model advances with the same inputs,
  // and the DUTs are compared 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    start = 0; abort = 0; dv = 0; din = 4'h0;
  endtask

  typedef struct {
    logic        st;
    logic        v;
    logic [3:0]  d;
    logic [3:0]  e_sig;
    logic [15:0] e_cnt;
    logic        e_busy;
    logic        e_done;
    logic        e_pass;
  } vec_t;

  vec_t tbl [15];
  logic [3:0] saved_sig;

  initial begin
    // Rows are checked on the WINDOW=2 instance, with expected_sig = 1000.
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'b0000, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'hF, 4'b1111, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'h5, 4'b1000, 16'd2, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 4'h0, 4'b0000, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'hF, 4'b1111, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'h4, 4'b1001, 16'd2, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 4'b0000, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'hF, 4'b1111, 16'd1, 1'b1, 1'b0, 1'b0};
    for (int r = 8; r < 13; r++)
      tbl[r] = '{1'b0, 1'b0, 4'h5, 4'b1111, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'h5, 4'b1000, 16'd2, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 4'hF, 4'b1000, 16'd2, 1'b0, 1'b1, 1'b1};

    idle_in();
    exp_sig = 4'b1000;
    rst_n   = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1;

    // Async reset mid-run, checked before any clock edge.
    start = 1; tick(); start = 0;
    dv = 1; din = 4'hA; tick();
    dv = 1; din = 4'h3; tick();
    rst_n = 0;
    model_reset();
    #2;
    compare_all();
    #1 rst_n = 1;
    // Data without start must be ignored.
    dv = 1; din = 4'hF;
    repeat (3) tick();
    chk("idle.sig_stays_0", int'(d_sig[0]), 0);
    chk("idle.count_stays_0", int'(d_cnt[1]), 0);
    idle_in();

    // XOR-chip vectors, fault case and valid gaps.
    for (int r = 0; r < 15; r++) begin
      start = tbl[r].st; dv = tbl[r].v; din = tbl[r].d;
      tick();
      chk($sformatf("tbl%0d.sig", r),   int'(d_sig[0]),  int'(tbl[r].e_sig));
      chk($sformatf("tbl%0d.count", r), int'(d_cnt[0]),  int'(tbl[r].e_cnt));
      chk($sformatf("tbl%0d.busy", r),  int'(d_busy[0]), int'(tbl[r].e_busy));
      chk($sformatf("tbl%0d.done", r),  int'(d_done[0]), int'(tbl[r].e_done));
      chk($sformatf("tbl%0d.pass", r),  int'(d_pass[0]), int'(tbl[r].e_pass));
    end
    idle_in();

    // WINDOW=16 with all-zero data. done must rise on exactly the 16th accept.
    abort = 1; tick(); abort = 0;
    exp_sig = 4'b0000;
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 16; k++) begin
      dv = 1; din = 4'h0; tick();
      chk($sformatf("w16z.done_at%0d", k), int'(d_done[1]), (k == 16) ? 1 : 0);
      chk($sformatf("w16z.sig_at%0d", k), int'(d_sig[1]), 0);
    end
    chk("w16z.pass", int'(d_pass[1]), 1);
    chk("w16z.count", int'(d_cnt[1]), 16);
    dv = 0;
    start = 1; tick(); start = 0;
    chk("w16z.restart_busy", int'(d_busy[1]), 1);
    chk("w16z.restart_count", int'(d_cnt[1]), 0);
    chk("w16z.restart_done", int'(d_done[1]), 0);

    // Abort beats start and data_valid after 3 accepts.
    for (int k = 0; k < 3; k++) begin
      dv = 1; din = 4'(k * 5 + 3); tick();
    end
    saved_sig = m_sig[1];
    abort = 1; start = 1; dv = 1; din = 4'hC;
    tick();
    idle_in();
    chk("abort.busy", int'(d_busy[1]), 0);
    chk("abort.done", int'(d_done[1]), 0);
    chk("abort.count", int'(d_cnt[1]), 0);
    chk("abort.sig_held", int'(d_sig[1]), int'(saved_sig));
    tick();
    chk("abort.stays_idle", int'(d_busy[1]), 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 39) == 0);
      dv    = ($urandom_range(0, 3) != 0);
      din   = 4'($urandom);
      if (start && $urandom_range(0, 1) == 0) exp_sig = 4'($urandom);
      tick();
    end
    idle_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
